// File: rtl/codec_packer.sv
// rtl/codec_packer.sv - packs pairs of 32-bit beats into 64-bit codec words
// Two-state FSM holds the low half; a single output register feeds the codec stage.
module codec_packer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_pad,
  output logic             busy,
  output logic [CNT_W-1:0] word_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HALF = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        lo_q, lo_d;
  logic [63:0]        out_data_q, out_data_d;
  logic               out_valid_q, out_valid_d;
  logic               out_pad_q, out_pad_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

  logic slot_free;
  logic in_fire;
  logic out_fire;
  logic load;

  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) ? 1'b1 : slot_free;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_pad_d   = out_pad_q;
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_fire) begin
          lo_d    = in_data;
          state_d = HALF;
        end
      end
      HALF: begin
        // An arriving beat beats a concurrent flush, so no padded word slips out.
        if (in_fire) begin
          out_data_d = {in_data, lo_q};
          out_pad_d  = 1'b0;
          load       = 1'b1;
          state_d    = IDLE;
        end else if (flush && !in_valid && slot_free) begin
          out_data_d = {32'h0, lo_q};
          out_pad_d  = 1'b1;
          load       = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  assign word_cnt_d = out_fire ? word_cnt_q + 1'b1 : word_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lo_q        <= 32'h0;
      out_data_q  <= 64'h0;
      out_valid_q <= 1'b0;
      out_pad_q   <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_pad_q   <= out_pad_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_pad   = out_pad_q;
  assign busy      = (state_q == HALF);
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_codec_packer.sv
// tb/tb_codec_packer.sv - self-checking bench for codec_packer
// Expected words are queued as beats are driven and popped when the DUT emits them.
module tb_codec_packer;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_data;
  logic             out_pad;
  logic             busy;
  logic [CNT_W-1:0] word_cnt;

  typedef struct packed {
    logic [63:0] data;
    logic        pad;
  } word_t;

  word_t exp_q[$];
  int checks = 0;
  int errors = 0;

  codec_packer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_pad   (out_pad),
    .busy      (busy),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send(input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout data=%h in_ready=%b required 1", d, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_word();
    int n;
    word_t w;
    n = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && n < 20) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!(out_valid && out_ready)) begin
      errors++;
      $display("FAIL word_timeout out_valid=%b required 1", out_valid);
    end else if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_word data=%h pad=%b required none", out_data, out_pad);
    end else begin
      w = exp_q.pop_front();
      if (out_data !== w.data || out_pad !== w.pad) begin
        errors++;
        $display("FAIL word data=%h pad=%b required data=%h pad=%b", out_data, out_pad, w.data, w.pad);
      end
    end
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || out_pad !== 1'b0 || busy !== 1'b0 || word_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_state valid=%b data=%h pad=%b busy=%b cnt=%0d required all 0",
               out_valid, out_data, out_pad, busy, word_cnt);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    exp_q.push_back('{data: 64'h3333_4444_1111_2222, pad: 1'b0});
    send(32'h1111_2222);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_half busy=%b out_valid=%b required busy=1 out_valid=0", busy, out_valid);
    end
    send(32'h3333_4444);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency out_valid=%b busy=%b required out_valid=1 busy=0", out_valid, busy);
    end
    expect_word();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || word_cnt !== 4'd1) begin
      errors++;
      $display("FAIL basic_after out_valid=%b cnt=%0d required out_valid=0 cnt=1", out_valid, word_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, c, d;
    a = 32'hA0A0_0001; b = 32'hB0B0_0002; c = 32'hC0C0_0003; d = 32'hD0D0_0004;
    out_ready = 1'b0;
    exp_q.push_back('{data: {b, a}, pad: 1'b0});
    exp_q.push_back('{data: {d, c}, pad: 1'b0});
    send(a);
    send(b);
    send(c);
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== {b, a} || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_stall cyc=%0d in_ready=%b valid=%b data=%h busy=%b required in_ready=0 valid=1 data=%h busy=1",
                 i, in_ready, out_valid, out_data, busy, {b, a});
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    expect_word();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_bubble out_valid=%b busy=%b required out_valid=1 busy=0", out_valid, busy);
    end
    expect_word();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    send(32'hDEAD_BEEF);
    exp_q.push_back('{data: 64'h0000_0000_DEAD_BEEF, pad: 1'b1});
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pad !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_emit valid=%b pad=%b busy=%b required valid=1 pad=1 busy=0", out_valid, out_pad, busy);
    end
    expect_word();
    @(posedge clk);
    #1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL flush_idle cyc=%0d valid=%b busy=%b required 0 0", i, out_valid, busy);
      end
    end
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic test_collision();
    out_ready = 1'b1;
    send(32'h5555_6666);
    exp_q.push_back('{data: 64'h7777_8888_5555_6666, pad: 1'b0});
    flush = 1'b1;
    send(32'h7777_8888);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pad !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL collision valid=%b pad=%b busy=%b required valid=1 pad=0 busy=0", out_valid, out_pad, busy);
    end
    expect_word();
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL collision_extra out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 6; i++) begin
      a = $urandom;
      b = $urandom;
      out_ready = 1'b0;
      exp_q.push_back('{data: {b, a}, pad: 1'b0});
      send(a);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      out_ready = 1'b1;
      expect_word();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a, b;
    logic [CNT_W-1:0] want;
    apply_reset();
    rst_n = 1'b1;
    #1;
    out_ready = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      a = $urandom;
      b = $urandom;
      exp_q.push_back('{data: {b, a}, pad: 1'b0});
      send(a);
      send(b);
      expect_word();
      @(posedge clk);
      #1;
      if (i >= 15) begin
        want = (i == 15) ? 4'd15 : (i == 16) ? 4'd0 : 4'd1;
        checks++;
        if (word_cnt !== want) begin
          errors++;
          $display("FAIL wrap word=%0d cnt=%0d required %0d", i, word_cnt, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h0101_0101);
    send(32'h0202_0202);
    send(32'h0303_0303);
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup busy=%b valid=%b required 1 1", busy, out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || out_pad !== 1'b0 || busy !== 1'b0 || word_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_async valid=%b data=%h pad=%b busy=%b cnt=%0d required all 0",
               out_valid, out_data, out_pad, busy, word_cnt);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release in_ready=%b valid=%b required 1 0", in_ready, out_valid);
    end
    out_ready = 1'b1;
    exp_q.push_back('{data: 64'h0F0F_0F0F_0E0E_0E0E, pad: 1'b0});
    send(32'h0E0E_0E0E);
    send(32'h0F0F_0F0F);
    expect_word();
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0 || word_cnt !== 4'd1) begin
      errors++;
      $display("FAIL mid_final pending=%0d cnt=%0d required 0 1", exp_q.size(), word_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_collision();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/codec_packer.md
CODEC_PACKER -- requirements
Module: codec_packer

Interface
REQ-001 Parameter CNT_W, default 16: width of the emitted-word counter.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset: clk is the clock, rst_n is the reset.
REQ-003 Ports:
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous active-low reset.
- in_valid  input  1: upstream beat valid.
- in_ready  output  1: packer accepts the beat this cycle.
- in_data  input  32: upstream beat data.
- flush  input  1: level request to emit a held half-word, zero-padded.
- out_valid  output  1: 64-bit word valid to the codec stage.
- out_ready  input  1: downstream accepts the word.
- out_data  output  64: packed word, feeds codec data_i.
- out_pad  output  1: out_data upper half is zero padding from a flush.
- busy  output  1: a low half-word is held (state HALF).
- word_cnt  output  CNT_W: count of words accepted downstream.

Function
REQ-004 The block SHALL pack two consecutive 32-bit input beats into one 64-bit word: the first beat goes to out_data[31:0] and the second to out_data[63:32].
REQ-005 The FSM SHALL have exactly two states, IDLE (no half held) and HALF (low half held in lo_q); busy SHALL be 1 exactly in HALF.
REQ-006 Define in_fire = in_valid & in_ready, out_fire = out_valid & out_ready, and slot_free = !out_valid | out_ready.
REQ-007 in_ready SHALL be combinational and equal 1 in IDLE, and equal slot_free in HALF.
REQ-008 On in_fire in IDLE, the block SHALL set lo_q to in_data and go to HALF; the output register SHALL be unchanged.
REQ-009 On in_fire in HALF, the block SHALL go to IDLE and on the same edge set out_data to {in_data, lo_q}, out_valid to 1 and out_pad to 0.
REQ-010 Input-to-output latency SHALL be 1 cycle after the second beat's in_fire edge.
REQ-011 out_valid SHALL clear on out_fire unless a new word is loaded on the same edge; a load SHALL take priority, giving back-to-back words with no bubble.
REQ-012 out_data and out_pad SHALL hold stable while out_valid=1 and out_ready=0.
REQ-013 Flush SHALL act only when flush=1, state=HALF, in_valid=0 and slot_free=1; it SHALL set out_data to {32'h0, lo_q}, out_valid to 1 and out_pad to 1, and go to IDLE.
REQ-014 If flush=1 and in_valid=1 in HALF, the input beat SHALL win and flush SHALL have no effect that cycle.
REQ-015 Flush in IDLE SHALL have no effect.
REQ-016 word_cnt SHALL increment by 1 on each out_fire, modulo 2^CNT_W, wrapping from all-ones to 0.
REQ-017 lo_q SHALL be an internal register and SHALL change only on in_fire in IDLE.

Reset
REQ-018 While rst_n=0 the block SHALL be forced, asynchronously, to: state IDLE, out_valid 0, out_data 0, out_pad 0, lo_q 0, word_cnt 0.
REQ-019 Reset asserted mid-word, in HALF or with out_valid=1, SHALL discard the held half-word and the pending output with no partial emission.
REQ-020 After reset release, in_ready SHALL be 1 on the first clock.

Verification
REQ-021 Basic pack: beats 32'h1111_2222 then 32'h3333_4444 with out_ready=1 -> out_valid for one cycle, out_data=64'h3333_4444_1111_2222, out_pad=0, word_cnt=1.
REQ-022 Back-pressure: out_ready=0 with 4 beats A,B,C,D offered -> word {B,A} held stable; C accepted; D stalls (in_ready=0); raise out_ready -> {B,A} then {D,C} on consecutive cycles.
REQ-023 Flush: one beat 32'hDEAD_BEEF, then flush=1 with in_valid=0 -> out_data=64'h0000_0000_DEAD_BEEF, out_pad=1, busy=0; flush in IDLE -> no output.
REQ-024 Flush collision: in HALF, flush=1 and in_valid=1 on the same cycle -> normal full word with out_pad=0; no padded word is emitted.
REQ-025 Counter wrap with CNT_W=4: 17 accepted words -> word_cnt reads 15, 0, 1 on the 15th, 16th and 17th words.
REQ-026 Reset mid-operation: assert rst_n=0 while busy=1 and out_valid=1 -> all outputs 0 immediately (asynchronously); the next two beats form a fresh word with no stale half.
